// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage IF/ID/EX/MEM/WB pipeline: stage-register enables,
// bubble inserts and stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter bit          FORWARDING = 1'b1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       fd_rs,
  input  logic [4:0]       fd_rt,
  input  logic             fd_uses_rt,
  input  logic [4:0]       de_dst_reg,
  input  logic             de_reg_write,
  input  logic             de_mem_read,
  input  logic [4:0]       em_dst_reg,
  input  logic             em_reg_write,
  input  logic             em_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  input  logic             cnt_clr,
  output logic             pc_wren,
  output logic             fd_wren,
  output logic             de_wren,
  output logic             em_wren,
  output logic             mw_wren,
  output logic             fd_bubble,
  output logic             de_bubble,
  output logic             em_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StLdStall = 2'd2,
    StIfWait  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic memwait, de_match, em_match, hazard, take_redirect;

  // r0 is hardwired to zero, so it never creates a dependency.
  assign de_match = (de_dst_reg != 5'd0) &&
                    ((de_dst_reg == fd_rs) || (fd_uses_rt && (de_dst_reg == fd_rt)));
  assign em_match = (em_dst_reg != 5'd0) &&
                    ((em_dst_reg == fd_rs) || (fd_uses_rt && (em_dst_reg == fd_rt)));

  assign memwait = dmem_req & ~dmem_ready;
  assign hazard  = FORWARDING ? (de_mem_read & de_reg_write & de_match)
                              : ((de_reg_write & de_match) | (em_reg_write & em_match));
  assign take_redirect = reset_n & ~memwait & em_redirect;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: depends only on this cycle's condition
  always_comb begin
    state_d = StRun;
    if (memwait) begin
      state_d = StMemWait;
    end else if (em_redirect) begin
      state_d = StRun;
    end else if (hazard) begin
      state_d = StLdStall;
    end else if (!imem_ready) begin
      state_d = StIfWait;
    end
  end

  // Output logic
  always_comb begin
    pc_wren   = 1'b0;
    fd_wren   = 1'b0;
    de_wren   = 1'b0;
    em_wren   = 1'b0;
    mw_wren   = 1'b0;
    fd_bubble = 1'b0;
    de_bubble = 1'b0;
    em_bubble = 1'b0;
    if (reset_n && !memwait) begin
      de_wren = 1'b1;
      em_wren = 1'b1;
      mw_wren = 1'b1;
      if (em_redirect) begin
        pc_wren   = 1'b1;
        fd_wren   = 1'b1;
        fd_bubble = 1'b1;
        de_bubble = 1'b1;
        em_bubble = 1'b1;
      end else if (hazard) begin
        // Hold PC and FD; the bubble drains the load so the stall lasts one cycle.
        de_bubble = 1'b1;
      end else if (!imem_ready) begin
        fd_wren   = 1'b1;
        fd_bubble = 1'b1;
      end else begin
        pc_wren = 1'b1;
        fd_wren = 1'b1;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (cnt_clr) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (!pc_wren) stall_d = stall_q + CNT_W'(1);
      if (take_redirect) flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a forwarding instance (32-bit counters) and a
// non-forwarding instance (4-bit counters) share stimulus and a priority-rule model.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] fd_rs, fd_rt, de_dst_reg, em_dst_reg;
  logic fd_uses_rt, de_reg_write, de_mem_read, em_reg_write, em_redirect;
  logic dmem_req, dmem_ready, imem_ready, cnt_clr;

  logic pc_f, fdw_f, dew_f, emw_f, mww_f, fdb_f, deb_f, emb_f;
  logic pc_n, fdw_n, dew_n, emw_n, mww_n, fdb_n, deb_n, emb_n;
  logic [1:0]  state_f, state_n;
  logic [31:0] stall_f, flush_f;
  logic [3:0]  stall_n, flush_n;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FORWARDING(1'b1), .CNT_W(32)) dut_f (
    .clk(clk), .reset_n(reset_n), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rt(fd_uses_rt),
    .de_dst_reg(de_dst_reg), .de_reg_write(de_reg_write), .de_mem_read(de_mem_read),
    .em_dst_reg(em_dst_reg), .em_reg_write(em_reg_write), .em_redirect(em_redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .imem_ready(imem_ready), .cnt_clr(cnt_clr),
    .pc_wren(pc_f), .fd_wren(fdw_f), .de_wren(dew_f), .em_wren(emw_f), .mw_wren(mww_f),
    .fd_bubble(fdb_f), .de_bubble(deb_f), .em_bubble(emb_f), .state(state_f),
    .stall_cnt(stall_f), .flush_cnt(flush_f)
  );

  pipeline_hazard_ctrl #(.FORWARDING(1'b0), .CNT_W(4)) dut_n (
    .clk(clk), .reset_n(reset_n), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rt(fd_uses_rt),
    .de_dst_reg(de_dst_reg), .de_reg_write(de_reg_write), .de_mem_read(de_mem_read),
    .em_dst_reg(em_dst_reg), .em_reg_write(em_reg_write), .em_redirect(em_redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .imem_ready(imem_ready), .cnt_clr(cnt_clr),
    .pc_wren(pc_n), .fd_wren(fdw_n), .de_wren(dew_n), .em_wren(emw_n), .mw_wren(mww_n),
    .fd_bubble(fdb_n), .de_bubble(deb_n), .em_bubble(emb_n), .state(state_n),
    .stall_cnt(stall_n), .flush_cnt(flush_n)
  );

  logic [4:0]  obs_wren  [2];
  logic [2:0]  obs_bub   [2];
  logic [1:0]  obs_state [2];
  logic [31:0] obs_stall [2];
  logic [31:0] obs_flush [2];
  assign obs_wren[0]  = {pc_f, fdw_f, dew_f, emw_f, mww_f};
  assign obs_wren[1]  = {pc_n, fdw_n, dew_n, emw_n, mww_n};
  assign obs_bub[0]   = {fdb_f, deb_f, emb_f};
  assign obs_bub[1]   = {fdb_n, deb_n, emb_n};
  assign obs_state[0] = state_f;
  assign obs_state[1] = state_n;
  assign obs_stall[0] = stall_f;
  assign obs_stall[1] = {28'd0, stall_n};
  assign obs_flush[0] = flush_f;
  assign obs_flush[1] = {28'd0, flush_n};

  // Reference state: reported state code and counters for each instance
  int unsigned m_state [2];
  int unsigned m_stall [2];
  int unsigned m_flush [2];
  int unsigned m_mask  [2] = '{32'hFFFF_FFFF, 32'h0000_000F};

  typedef struct packed {
    logic [4:0] wren;   // {pc, fd, de, em, mw}
    logic [2:0] bub;    // {fd, de, em}
    logic [1:0] nxt;
    logic       flush;
  } exp_t;

  function automatic bit reads(input logic [4:0] x);
    return (x != 5'd0) && ((x == fd_rs) || (fd_uses_rt && (x == fd_rt)));
  endfunction

  function automatic exp_t model(input bit fwd);
    exp_t e;
    bit hz;
    hz = fwd ? (de_mem_read && de_reg_write && reads(de_dst_reg))
             : ((de_reg_write && reads(de_dst_reg)) || (em_reg_write && reads(em_dst_reg)));
    if (dmem_req && !dmem_ready) e = '{wren: 5'b00000, bub: 3'b000, nxt: 2'd1, flush: 1'b0};
    else if (em_redirect)        e = '{wren: 5'b11111, bub: 3'b111, nxt: 2'd0, flush: 1'b1};
    else if (hz)                 e = '{wren: 5'b00111, bub: 3'b010, nxt: 2'd2, flush: 1'b0};
    else if (!imem_ready)        e = '{wren: 5'b01111, bub: 3'b100, nxt: 2'd3, flush: 1'b0};
    else                         e = '{wren: 5'b11111, bub: 3'b000, nxt: 2'd0, flush: 1'b0};
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    fd_rs = 5'd1; fd_rt = 5'd0; fd_uses_rt = 1'b0;
    de_dst_reg = 5'd0; de_reg_write = 1'b0; de_mem_read = 1'b0;
    em_dst_reg = 5'd0; em_reg_write = 1'b0; em_redirect = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1; cnt_clr = 1'b0;
  endtask

  task automatic set_random();
    fd_rs        = 5'($urandom_range(0, 3));
    fd_rt        = 5'($urandom_range(0, 3));
    fd_uses_rt   = 1'($urandom_range(0, 1));
    de_dst_reg   = 5'($urandom_range(0, 3));
    de_reg_write = 1'($urandom_range(0, 1));
    de_mem_read  = 1'($urandom_range(0, 1));
    em_dst_reg   = 5'($urandom_range(0, 3));
    em_reg_write = 1'($urandom_range(0, 1));
    em_redirect  = ($urandom_range(0, 5) == 0);
    dmem_req     = ($urandom_range(0, 3) == 0);
    dmem_ready   = 1'($urandom_range(0, 1));
    imem_ready   = ($urandom_range(0, 3) != 0);
    cnt_clr      = ($urandom_range(0, 40) == 0);
  endtask

  // Inputs are already applied; check mid-cycle, then advance the model past the edge.
  task automatic cycle(input string tag);
    exp_t e [2];
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      e[i] = model(i == 0);
      check({tag, (i == 0) ? "/f/wren" : "/n/wren"}, 32'(obs_wren[i]), 32'(e[i].wren));
      check({tag, (i == 0) ? "/f/bub" : "/n/bub"}, 32'(obs_bub[i]), 32'(e[i].bub));
      check({tag, (i == 0) ? "/f/state" : "/n/state"}, 32'(obs_state[i]), m_state[i]);
      check({tag, (i == 0) ? "/f/stall" : "/n/stall"}, obs_stall[i], m_stall[i]);
      check({tag, (i == 0) ? "/f/flush" : "/n/flush"}, obs_flush[i], m_flush[i]);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (cnt_clr) begin
        m_stall[i] = 0;
        m_flush[i] = 0;
      end else begin
        if (!e[i].wren[4]) m_stall[i] = (m_stall[i] + 1) & m_mask[i];
        if (e[i].flush)    m_flush[i] = (m_flush[i] + 1) & m_mask[i];
      end
      m_state[i] = 32'(e[i].nxt);
    end
  endtask

  task automatic reset_check(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, (i == 0) ? "/f/wren" : "/n/wren"}, 32'(obs_wren[i]), 32'd0);
      check({tag, (i == 0) ? "/f/bub" : "/n/bub"}, 32'(obs_bub[i]), 32'd0);
      check({tag, (i == 0) ? "/f/state" : "/n/state"}, 32'(obs_state[i]), 32'd0);
      check({tag, (i == 0) ? "/f/stall" : "/n/stall"}, obs_stall[i], 32'd0);
      check({tag, (i == 0) ? "/f/flush" : "/n/flush"}, obs_flush[i], 32'd0);
      m_state[i] = 0;
      m_stall[i] = 0;
      m_flush[i] = 0;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    set_idle();
    #2;
    reset_check("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Load-use on rs
    de_mem_read = 1'b1; de_reg_write = 1'b1; de_dst_reg = 5'd2; fd_rs = 5'd2;
    cycle("t1_stall");
    set_idle();
    cycle("t1_after");
    check("t1_stall_cnt", stall_f, 32'd1);

    // r0 destination never stalls
    de_mem_read = 1'b1; de_reg_write = 1'b1; de_dst_reg = 5'd0; fd_rs = 5'd0;
    cycle("t2_r0");

    // Redirect wins over a simultaneous load-use
    set_idle();
    de_mem_read = 1'b1; de_reg_write = 1'b1; de_dst_reg = 5'd3; fd_rs = 5'd3;
    em_redirect = 1'b1;
    cycle("t3_redirect");
    check("t3_flush_cnt", flush_f, 32'd1);

    // Clear counters, then a redirect held behind a 3-cycle data-memory wait
    set_idle();
    cnt_clr = 1'b1;
    cycle("t4_clr");
    cnt_clr = 1'b0; dmem_req = 1'b1; dmem_ready = 1'b0; em_redirect = 1'b1;
    for (int i = 0; i < 3; i++) cycle("t4_memwait");
    check("t4_state", 32'(state_f), 32'd1);
    dmem_ready = 1'b1;
    cycle("t4_release");
    check("t4_stall_cnt", stall_f, 32'd3);
    check("t4_flush_cnt", flush_f, 32'd1);

    // Non-forwarding RAW on rt against EM
    set_idle();
    em_reg_write = 1'b1; em_dst_reg = 5'd5; fd_rt = 5'd5; fd_uses_rt = 1'b1;
    cycle("t5_rt_used");
    fd_uses_rt = 1'b0;
    cycle("t5_rt_unused");

    // Fetch wait interrupted by reset
    set_idle();
    imem_ready = 1'b0;
    cycle("t6_ifwait0");
    cycle("t6_ifwait1");
    check("t6_state", 32'(state_f), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    reset_check("t6_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    set_idle();
    cycle("t6_resume");

    // Random traffic; 4-bit counters wrap along the way
    for (int n = 0; n < 600; n++) begin
      set_random();
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
